// File: rtl/fpdivsqrt_iter.sv
// rtl/fpdivsqrt_iter.sv - iterative parametrised floating-point divide / square-root unit
//
// One operation in flight. Operands are unpacked and special cases are
// classified on the accepting edge, then MW+3 radix-2 iterations produce the
// significand plus guard and round bits. A single ROUND cycle follows, so the
// latency is fixed at MW+4 edges whatever the operands are.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (op, rm, n, d captured on accept)
//   op                   00 divide n/d, 01 sqrt(n), 1x executes as divide
//   rm                   0 round-to-nearest-even, 1 round-toward-zero
//   out_valid/out_ready  result handshake; result and flags held until taken
//   result, flags        packed result, {NV, DZ, OF, UF, NX}
module fpdivsqrt_iter #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic           rm,
  input  logic [EW+MW:0] n,
  input  logic [EW+MW:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] result,
  output logic [4:0]     flags
);
  localparam int W    = 1 + EW + MW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int SW   = MW + 1;       // significand with hidden bit
  localparam int QW   = MW + 3;       // significand + guard + round
  localparam int RW   = MW + 6;       // partial remainder
  localparam int XW   = 2 * MW + 6;   // sqrt radicand, two bits consumed per step
  localparam int ESW  = EW + 2;       // signed working exponent
  localparam int CW   = $clog2(QW);
  localparam logic [CW-1:0]         LAST   = CW'(QW - 1);
  localparam logic signed [ESW-1:0] BIAS_S = ESW'(BIAS);
  localparam logic signed [ESW-1:0] EMAX   = ESW'((1 << EW) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;
  state_t state_q, state_d;

  logic                  accept;
  logic [RW-1:0]         rem_q, rem_nx, init_rem;
  logic [QW-1:0]         q_q, q_nx;
  logic [XW-1:0]         rad_q, init_rad;
  logic [SW-1:0]         div_q;
  logic signed [ESW-1:0] exp_q, init_exp;
  logic                  sign_q, init_sign, sqrt_q, rm_q;
  logic                  spec, spec_q;
  logic [W-1:0]          spec_res, spec_res_q, round_res;
  logic [4:0]            spec_flags, spec_flags_q, round_flags;
  logic [CW-1:0]         cnt_q;

  // Operand unpacking; subnormals (zero exponent) classify as zero.
  logic          sn, sd;
  logic [EW-1:0] en, ed;
  logic [MW-1:0] mn, md;
  assign {sn, en, mn} = n;
  assign {sd, ed, md} = d;

  logic n_zero, n_inf, n_nan, n_snan, d_zero, d_inf, d_nan, d_snan, is_sqrt, n_lt;
  assign n_zero  = (en == '0);
  assign n_inf   = (&en) && (mn == '0);
  assign n_nan   = (&en) && (mn != '0);
  assign n_snan  = n_nan && !mn[MW-1];
  assign d_zero  = (ed == '0);
  assign d_inf   = (&ed) && (md == '0);
  assign d_nan   = (&ed) && (md != '0);
  assign d_snan  = d_nan && !md[MW-1];
  assign is_sqrt = (op == 2'b01);

  logic [SW-1:0]         sig_n, sig_d;
  logic signed [ESW-1:0] en_s, ed_s, unb_n;
  assign sig_n = {1'b1, mn};
  assign sig_d = {1'b1, md};
  assign n_lt  = sig_n < sig_d;
  assign en_s  = ESW'(en);
  assign ed_s  = ESW'(ed);
  assign unb_n = en_s - BIAS_S;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);

  // Initial recurrence state. A dividend below the divisor is pre-doubled so
  // the first quotient bit is always the hidden 1; an odd sqrt exponent
  // doubles the radicand so the halved exponent is exact.
  always_comb begin
    init_rem  = '0;
    init_rad  = '0;
    init_exp  = '0;
    init_sign = 1'b0;
    if (is_sqrt) begin
      init_exp = (unb_n >>> 1) + BIAS_S;
      init_rad = unb_n[0] ? {sig_n, {(MW+5){1'b0}}} : {1'b0, sig_n, {(MW+4){1'b0}}};
    end else begin
      init_exp  = en_s - ed_s + BIAS_S - ESW'(n_lt);
      init_sign = sn ^ sd;
      init_rem  = n_lt ? RW'({sig_n, 1'b0}) : RW'(sig_n);
    end
  end

  // Special operands, highest priority first; resolved at accept and only
  // selected in ROUND so that latency does not depend on them.
  always_comb begin
    spec       = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (is_sqrt) begin
      if (n_nan) begin
        spec_res      = QNAN;
        spec_flags[4] = n_snan;
      end else if (sn && !n_zero) begin
        spec_res      = QNAN;
        spec_flags[4] = 1'b1;
      end else if (n_zero) spec_res = {sn, {(W-1){1'b0}}};
      else if (n_inf)      spec_res = {1'b0, {EW{1'b1}}, {MW{1'b0}}};
      else                 spec = 1'b0;
    end else begin
      if (n_nan || d_nan) begin
        spec_res      = QNAN;
        spec_flags[4] = n_snan || d_snan;
      end else if ((n_zero && d_zero) || (n_inf && d_inf)) begin
        spec_res      = QNAN;
        spec_flags[4] = 1'b1;
      end else if (d_zero && !n_inf) begin
        spec_res      = {sn ^ sd, {EW{1'b1}}, {MW{1'b0}}};
        spec_flags[3] = 1'b1;
      end else if (n_inf)           spec_res = {sn ^ sd, {EW{1'b1}}, {MW{1'b0}}};
      else if (d_inf || n_zero)     spec_res = {sn ^ sd, {(W-1){1'b0}}};
      else                          spec = 1'b0;
    end
  end

  // One recurrence step: restoring division, or bit-pair square root where
  // the trial subtrahend is 4*root + 1.
  logic [RW-1:0] rem_sh, trial;
  logic          ge;
  always_comb begin
    rem_sh = {rem_q[RW-3:0], rad_q[XW-1:XW-2]};
    trial  = {1'b0, q_q, 2'b01};
    ge     = 1'b0;
    rem_nx = rem_q;
    if (sqrt_q) begin
      ge     = rem_sh >= trial;
      rem_nx = ge ? rem_sh - trial : rem_sh;
    end else begin
      ge     = rem_q >= RW'(div_q);
      rem_nx = (ge ? rem_q - RW'(div_q) : rem_q) << 1;
    end
    q_nx = {q_q[QW-2:0], ge};
  end

  // Rounding and range handling of the finished quotient / root.
  logic                  g_b, r_b, st_b, inc, nx;
  logic [SW:0]           sig_r;
  logic [MW-1:0]         mant_r;
  logic signed [ESW-1:0] exp_r;
  assign g_b    = q_q[1];
  assign r_b    = q_q[0];
  assign st_b   = |rem_q;
  assign nx     = g_b || r_b || st_b;
  assign inc    = !rm_q && g_b && (r_b || st_b || q_q[2]);
  assign sig_r  = {1'b0, q_q[QW-1:2]} + (SW+1)'(inc);
  assign mant_r = sig_r[SW] ? sig_r[MW:1] : sig_r[MW-1:0];
  assign exp_r  = exp_q + ESW'(sig_r[SW]);

  always_comb begin
    round_res   = {sign_q, exp_r[EW-1:0], mant_r};
    round_flags = {4'b0000, nx};
    if (!exp_r[ESW-1] && exp_r >= EMAX) begin
      round_res   = rm_q ? {sign_q, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}}
                         : {sign_q, {EW{1'b1}}, {MW{1'b0}}};
      round_flags = 5'b00101;
    end else if (exp_r[ESW-1] || exp_r == '0) begin
      round_res   = {sign_q, {(W-1){1'b0}}};
      round_flags = 5'b00011;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ITER;
      ITER:    if (cnt_q == LAST) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? ITER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q        <= '0;
      q_q          <= '0;
      rad_q        <= '0;
      div_q        <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      sqrt_q       <= 1'b0;
      rm_q         <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      cnt_q        <= '0;
      result       <= '0;
      flags        <= '0;
    end else if (accept) begin
      rem_q        <= init_rem;
      q_q          <= '0;
      rad_q        <= init_rad;
      div_q        <= sig_d;
      exp_q        <= init_exp;
      sign_q       <= init_sign;
      sqrt_q       <= is_sqrt;
      rm_q         <= rm;
      spec_q       <= spec;
      spec_res_q   <= spec_res;
      spec_flags_q <= spec_flags;
      cnt_q        <= '0;
      result       <= '0;
      flags        <= '0;
    end else if (state_q == ITER) begin
      rem_q <= rem_nx;
      q_q   <= q_nx;
      rad_q <= rad_q << 2;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == ROUND) begin
      result <= spec_q ? spec_res_q : round_res;
      flags  <= spec_q ? spec_flags_q : round_flags;
    end
  end
endmodule

// File: tb/tb_fpdivsqrt_iter.sv
// tb/tb_fpdivsqrt_iter.sv - scoreboard bench for fpdivsqrt_iter (f32 defaults)
module tb_fpdivsqrt_iter;
  localparam int LAT = 27;
  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_DZ = 5'b01000;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [4:0] F_NX = 5'b00001;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, rm, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] n, d, result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [36:0] exp_q[$];
  int          acc_q[$];
  bit          prev_v = 1'b0;

  always #5 clk = ~clk;

  fpdivsqrt_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rm(rm), .n(n), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: records accepts, checks latency on each rising out_valid and
  // pops the scoreboard whenever a result is transferred.
  always @(negedge clk) begin
    logic [36:0] e;
    cyc++;
    if (reset) begin
      acc_q.delete();
      prev_v = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_v) begin
        if (acc_q.size() == 0) fail("latency_no_accept");
        else chk("latency", 32'(cyc - acc_q.pop_front() - 1), LAT);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else begin
          e = exp_q.pop_front();
          chk("result", result, e[36:5]);
          chk("flags", 32'(flags), 32'(e[4:0]));
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [1:0] o, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [4:0] ef);
    bit ok;
    exp_q.push_back({er, ef});
    @(posedge clk); #1;
    op = o; rm = r; n = a; d = b; in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) fail("issue_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fail("drain_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; op = 2'b00; rm = 1'b0;
    n = '0; d = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_result", result, 32'h0);
    chk("reset_flags", 32'(flags), 0);

    issue(2'b00, 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b0);
    issue(2'b00, 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NX);
    issue(2'b00, 1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NX);
    issue(2'b01, 1'b0, 32'h40800000, 32'h00000000, 32'h40000000, 5'b0);
    issue(2'b01, 1'b0, 32'h40000000, 32'h00000000, 32'h3FB504F3, F_NX);
    issue(2'b01, 1'b0, 32'hBF800000, 32'h00000000, 32'h7FC00000, F_NV);
    issue(2'b00, 1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, F_DZ);
    issue(2'b00, 1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, F_NV);
    issue(2'b00, 1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, F_OF | F_NX);
    issue(2'b00, 1'b1, 32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, F_OF | F_NX);
    drain();

    // Consumer stall, then release together with a new request.
    out_ready = 1'b0;
    issue(2'b00, 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b0);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) fail("stall_wait_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall_result", result, 32'h40400000);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_q.push_back({32'h3EAAAAAB, F_NX});
    op = 2'b00; rm = 1'b0; n = 32'h3F800000; d = 32'h40400000;
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of an operation.
    issue(2'b00, 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 1);
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_out_valid", 32'(seen), 0);
    issue(2'b01, 1'b0, 32'h40800000, 32'h00000000, 32'h40000000, 5'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
